// File: rtl/isa_pkg.sv
// Shared definitions for the data-RAM arbiter slice.
//   ANCHO_DEF / PROF_DIR_DEF : default data and address widths
//   estado_t                 : sequencer states (REPOSO, LECTURA, RESPUESTA)
//   PUERTO_A / PUERTO_B      : port identifiers, also used as priority/owner values
package isa_pkg;

    localparam int ANCHO_DEF    = 32;
    localparam int PROF_DIR_DEF = 5;

    typedef enum logic [1:0] {
        REPOSO    = 2'd0,
        LECTURA   = 2'd1,
        RESPUESTA = 2'd2
    } estado_t;

    localparam logic PUERTO_A = 1'b0;
    localparam logic PUERTO_B = 1'b1;

endpackage

// File: rtl/arbitro_rr2.sv
// Two-way round-robin arbiter.
//   en       : arbitration allowed this cycle (sequencer idle)
//   req[1:0] : requests, bit 0 = port A, bit 1 = port B
//   prio     : port currently holding priority
//   gnt[1:0] : one-hot grant, zero when disabled or no request
//   prioNext : priority for the next cycle (the non-granted port, or unchanged)
module arbitro_rr2
    import isa_pkg::*;
(
    input  logic       en,
    input  logic [1:0] req,
    input  logic       prio,
    output logic [1:0] gnt,
    output logic       prioNext
);

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt = (prio == PUERTO_A) ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end

        // An idle cycle leaves priority where it is.
        prioNext = prio;
        if (gnt[0]) begin
            prioNext = PUERTO_B;
        end else if (gnt[1]) begin
            prioNext = PUERTO_A;
        end
    end

endmodule

// File: rtl/ram_arbitro.sv
// Arbiter and sequencer sharing one synchronous-read RAM port between the core
// load/store path (port A) and the debug/load port (port B).
//
// Handshake: a port raises x_req with x_we/x_dir/x_dato valid and holds them
// until x_gnt is seen high in the same cycle; that cycle is the transfer. Dropping
// x_req before a grant is legal and issues nothing. A read grant is answered two
// cycles later by a one-cycle x_valido pulse, with x_dato_l holding the data.
//
// Ports:
//   clk, rst_n                : clock, asynchronous active-low reset
//   a_* / b_*                 : request side of port A / port B
//   ram_we, ram_re, ram_dir,
//   ram_dato_e, ram_dato_s    : RAM control, address, write data, read data
//   estadoDbg                 : current sequencer state, for observation
module ram_arbitro
    import isa_pkg::*;
#(
    parameter int ANCHO    = ANCHO_DEF,
    parameter int PROF_DIR = PROF_DIR_DEF
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                a_req,
    input  logic                a_we,
    input  logic [PROF_DIR-1:0] a_dir,
    input  logic [ANCHO-1:0]    a_dato,
    output logic                a_gnt,
    output logic                a_valido,
    output logic [ANCHO-1:0]    a_dato_l,

    input  logic                b_req,
    input  logic                b_we,
    input  logic [PROF_DIR-1:0] b_dir,
    input  logic [ANCHO-1:0]    b_dato,
    output logic                b_gnt,
    output logic                b_valido,
    output logic [ANCHO-1:0]    b_dato_l,

    output logic                ram_we,
    output logic                ram_re,
    output logic [PROF_DIR-1:0] ram_dir,
    output logic [ANCHO-1:0]    ram_dato_e,
    input  logic [ANCHO-1:0]    ram_dato_s,

    output estado_t             estadoDbg
);

    estado_t    estado;
    logic       prio;
    logic       prioNext;
    logic       duenio;     // port whose read is in flight
    logic [1:0] gnt;

    arbitro_rr2 uArb (
        .en       (estado == REPOSO),
        .req      ({b_req, a_req}),
        .prio     (prio),
        .gnt      (gnt),
        .prioNext (prioNext)
    );

    assign a_gnt     = gnt[0];
    assign b_gnt     = gnt[1];
    assign estadoDbg = estado;

    // The granted port drives the RAM directly in its grant cycle.
    always_comb begin
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        ram_dir    = '0;
        ram_dato_e = '0;
        if (gnt[1]) begin
            ram_we     = b_we;
            ram_re     = !b_we;
            ram_dir    = b_dir;
            ram_dato_e = b_dato;
        end else if (gnt[0]) begin
            ram_we     = a_we;
            ram_re     = !a_we;
            ram_dir    = a_dir;
            ram_dato_e = a_dato;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado   <= REPOSO;
            prio     <= PUERTO_A;
            duenio   <= PUERTO_A;
            a_valido <= 1'b0;
            b_valido <= 1'b0;
            a_dato_l <= '0;
            b_dato_l <= '0;
        end else begin
            a_valido <= 1'b0;
            b_valido <= 1'b0;
            prio     <= prioNext;
            case (estado)
                REPOSO: begin
                    // Writes finish in the grant cycle; only reads leave REPOSO.
                    if (ram_re) begin
                        duenio <= gnt[1];
                        estado <= LECTURA;
                    end
                end
                LECTURA: begin
                    // RAM data is valid now; register it and flag it for one cycle.
                    if (duenio == PUERTO_B) begin
                        b_dato_l <= ram_dato_s;
                        b_valido <= 1'b1;
                    end else begin
                        a_dato_l <= ram_dato_s;
                        a_valido <= 1'b1;
                    end
                    estado <= RESPUESTA;
                end
                RESPUESTA: begin
                    estado <= REPOSO;
                end
                default: begin
                    estado <= REPOSO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbitro.sv
module tb_ram_arbitro;
    import isa_pkg::*;

    localparam int W  = 32;
    localparam int AW = 5;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT connections ----------------
    logic          req_v  [2];
    logic          we_v   [2];
    logic [AW-1:0] dir_v  [2];
    logic [W-1:0]  dato_v [2];

    logic          a_gnt, b_gnt, a_valido, b_valido;
    logic [W-1:0]  a_dato_l, b_dato_l;
    logic          ram_we, ram_re;
    logic [AW-1:0] ram_dir;
    logic [W-1:0]  ram_dato_e, ram_dato_s;
    estado_t       estadoDbg;

    ram_arbitro #(.ANCHO(W), .PROF_DIR(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a_req      (req_v[0]),
        .a_we       (we_v[0]),
        .a_dir      (dir_v[0]),
        .a_dato     (dato_v[0]),
        .a_gnt      (a_gnt),
        .a_valido   (a_valido),
        .a_dato_l   (a_dato_l),
        .b_req      (req_v[1]),
        .b_we       (we_v[1]),
        .b_dir      (dir_v[1]),
        .b_dato     (dato_v[1]),
        .b_gnt      (b_gnt),
        .b_valido   (b_valido),
        .b_dato_l   (b_dato_l),
        .ram_we     (ram_we),
        .ram_re     (ram_re),
        .ram_dir    (ram_dir),
        .ram_dato_e (ram_dato_e),
        .ram_dato_s (ram_dato_s),
        .estadoDbg  (estadoDbg)
    );

    // RAM: synchronous write, synchronous read with one cycle latency.
    logic [W-1:0] ram_mem [32];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_dir] <= ram_dato_e;
        if (ram_re) ram_dato_s <= ram_mem[ram_dir];
    end

    // ---------------- scoreboard bookkeeping ----------------
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct { int cyc; int p; bit we; }          gev_t;
    typedef struct { int cyc; int p; logic [W-1:0] d; } vev_t;
    gev_t gnt_log[$];
    vev_t val_log[$];

    function automatic int g_port(input int i);
        return (i < gnt_log.size()) ? gnt_log[i].p : -1;
    endfunction
    function automatic int g_cyc(input int i);
        return (i < gnt_log.size()) ? gnt_log[i].cyc : -1;
    endfunction
    function automatic logic [W-1:0] v_dat(input int i);
        return (i < val_log.size()) ? val_log[i].d : 'x;
    endfunction
    function automatic int v_cyc(input int i);
        return (i < val_log.size()) ? val_log[i].cyc : -1;
    endfunction
    function automatic int v_port(input int i);
        return (i < val_log.size()) ? val_log[i].p : -1;
    endfunction

    // ---------------- behavioural model ----------------
    // Memory image, who has priority, and the one read that may be outstanding
    // (age = cycles since its grant; result shows up at age 2).
    logic [W-1:0] m_mem [32];
    logic [W-1:0] m_dl  [2];
    logic [W-1:0] m_data;
    int           m_pri, m_owner, m_age;
    bit           m_pend;
    bit           gnt_seen [2];
    int           eg, vp;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_pri = 0; m_pend = 0; m_age = 0;
            m_dl[0] = '0; m_dl[1] = '0;
            gnt_seen[0] = 0; gnt_seen[1] = 0;
            chk("rst_gnt",    {a_gnt, b_gnt}, 0);
            chk("rst_valido", {a_valido, b_valido}, 0);
            chk("rst_ram_ctl", {ram_we, ram_re}, 0);
            chk("rst_ram_dir", ram_dir, 0);
            chk("rst_ram_dato_e", ram_dato_e, 0);
            chk("rst_a_dato_l", a_dato_l, 0);
            chk("rst_b_dato_l", b_dato_l, 0);
        end else begin
            eg = -1;
            vp = -1;
            if (m_pend && m_age == 2) begin
                m_dl[m_owner] = m_data;
                vp = m_owner;
            end
            if (!m_pend) begin
                if (req_v[0] && req_v[1]) eg = m_pri;
                else if (req_v[0])        eg = 0;
                else if (req_v[1])        eg = 1;
            end
            chk("a_gnt", a_gnt, eg == 0);
            chk("b_gnt", b_gnt, eg == 1);
            chk("ram_we", ram_we, (eg >= 0) && we_v[(eg >= 0) ? eg : 0]);
            chk("ram_re", ram_re, (eg >= 0) && !we_v[(eg >= 0) ? eg : 0]);
            chk("ram_dir", ram_dir, (eg >= 0) ? dir_v[eg] : '0);
            chk("ram_dato_e", ram_dato_e, (eg >= 0) ? dato_v[eg] : '0);
            chk("a_valido", a_valido, vp == 0);
            chk("b_valido", b_valido, vp == 1);
            chk("a_dato_l", a_dato_l, m_dl[0]);
            chk("b_dato_l", b_dato_l, m_dl[1]);

            if (a_gnt)    gnt_log.push_back('{cyc, 0, we_v[0]});
            if (b_gnt)    gnt_log.push_back('{cyc, 1, we_v[1]});
            if (a_valido) val_log.push_back('{cyc, 0, a_dato_l});
            if (b_valido) val_log.push_back('{cyc, 1, b_dato_l});
            gnt_seen[0] = a_gnt;
            gnt_seen[1] = b_gnt;

            if (m_pend) begin
                if (m_age == 2) m_pend = 0;
                else            m_age++;
            end else if (eg >= 0) begin
                m_pri = (eg == 0) ? 1 : 0;
                if (we_v[eg]) begin
                    m_mem[dir_v[eg]] = dato_v[eg];
                end else begin
                    m_pend  = 1;
                    m_age   = 1;
                    m_owner = eg;
                    m_data  = m_mem[dir_v[eg]];
                end
            end
        end
    end

    // ---------------- drivers ----------------
    typedef struct { bit we; logic [AW-1:0] dir; logic [W-1:0] dato; int gap; int pat; } job_t;
    job_t job_q0[$];
    job_t job_q1[$];
    bit   act_v [2];

    function automatic int q_size(input int p);
        return (p == 0) ? job_q0.size() : job_q1.size();
    endfunction
    function automatic job_t q_pop(input int p);
        return (p == 0) ? job_q0.pop_front() : job_q1.pop_front();
    endfunction
    function automatic void push_job(input int p, input bit we, input int dir, input logic [W-1:0] dato,
                                     input int gap = 0, input int pat = 0);
        job_t j;
        j.we = we; j.dir = dir[AW-1:0]; j.dato = dato; j.gap = gap; j.pat = pat;
        if (p == 0) job_q0.push_back(j);
        else        job_q1.push_back(j);
    endfunction

    // Holds a request until granted (or until its patience runs out, which
    // abandons it without a grant), then takes the next job.
    task automatic drive_port(input int p);
        job_t cur;
        int   held;
        int   waitc;
        held  = 0;
        waitc = 0;
        forever begin
            @(posedge clk); #1;
            if (act_v[p] && gnt_seen[p]) act_v[p] = 0;
            else if (act_v[p] && waitc == 0 && cur.pat != 0 && held >= cur.pat) act_v[p] = 0;
            if (!act_v[p] && q_size(p) > 0 && rst_n) begin
                cur      = q_pop(p);
                act_v[p] = 1;
                held     = 0;
                waitc    = cur.gap;
            end
            if (act_v[p] && rst_n && waitc == 0) begin
                req_v[p]  = 1'b1;
                we_v[p]   = cur.we;
                dir_v[p]  = cur.dir;
                dato_v[p] = cur.dato;
                held++;
            end else begin
                if (waitc > 0) waitc--;
                req_v[p]  = 1'b0;
                we_v[p]   = 1'($urandom_range(0, 1));
                dir_v[p]  = AW'($urandom_range(0, 31));
                dato_v[p] = $urandom;
            end
        end
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((job_q0.size() != 0 || job_q1.size() != 0 || act_v[0] || act_v[1] || m_pend) && n < budget);
        chk(nm, n < budget, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, n1, v0, k;
        for (int i = 0; i < 32; i++) begin
            ram_mem[i] = '0;
            m_mem[i]   = '0;
        end
        for (int p = 0; p < 2; p++) begin
            req_v[p] = 1'b0; we_v[p] = 1'b0; dir_v[p] = '0; dato_v[p] = '0; act_v[p] = 0;
        end
        fork
            drive_port(0);
            drive_port(1);
        join_none

        // Reset then idle.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_estado", estadoDbg, REPOSO);
        chk("rst_lit_a_gnt", a_gnt, 0);
        @(posedge clk); #2 rst_n = 1'b1;

        // Single write from A.
        @(negedge clk);
        n0 = gnt_log.size();
        push_job(0, 1, 3, 32'hDEADBEEF);
        wait_idle("t1_done", 100);
        chk("t1_gnt_port", g_port(n0), 0);
        chk("t1_model_mem", m_mem[3], 32'hDEADBEEF);
        chk("t1_ram_mem", ram_mem[3], 32'hDEADBEEF);

        // Read-back from B: valido two cycles after the grant.
        n0 = gnt_log.size();
        v0 = val_log.size();
        push_job(1, 0, 3, 0);
        wait_idle("t2_done", 100);
        chk("t2_gnt_port", g_port(n0), 1);
        chk("t2_val_count", val_log.size(), v0 + 1);
        chk("t2_val_port", v_port(v0), 1);
        chk("t2_val_cyc", v_cyc(v0), g_cyc(n0) + 2);
        chk("t2_val_data", v_dat(v0), 32'hDEADBEEF);

        // Simultaneous write/read to the same address right after reset.
        do_reset();
        @(negedge clk);
        n0 = gnt_log.size();
        v0 = val_log.size();
        push_job(0, 1, 7, 32'h11);
        push_job(1, 0, 7, 0);
        wait_idle("t3_done", 100);
        chk("t3_first_port", g_port(n0), 0);
        chk("t3_second_port", g_port(n0 + 1), 1);
        chk("t3_second_cyc", g_cyc(n0 + 1), g_cyc(n0) + 1);
        chk("t3_val_data", v_dat(v0), 32'h11);
        chk("t3_val_cyc", v_cyc(v0), g_cyc(n0 + 1) + 2);
        push_job(0, 1, 7, 32'h22);
        push_job(1, 0, 7, 0);
        wait_idle("t3b_done", 100);

        // Write streaming from A against a held read request from B.
        n0 = gnt_log.size();
        v0 = val_log.size();
        for (int i = 0; i < 4; i++) push_job(0, 1, i, i + 1);
        for (int i = 0; i < 3; i++) push_job(1, 0, i, 0);
        wait_idle("t4_done", 200);
        for (int i = 0; i < 7; i++) begin
            chk("t4_order", g_port(n0 + i), i % 2);
            if (i < 6) chk("t4_spacing", g_cyc(n0 + i + 1) - g_cyc(n0 + i), (i % 2 == 0) ? 1 : 3);
        end
        for (int i = 0; i < 3; i++) chk("t4_read_data", v_dat(v0 + i), i + 1);

        // Reset while a read is in LECTURA.
        push_job(0, 1, 9, 32'hCAFE0009);
        wait_idle("t5_pre", 100);
        v0 = val_log.size();
        push_job(1, 0, 9, 0);
        k = 0;
        @(negedge clk);
        while (!b_gnt && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("t5_gnt_seen", b_gnt, 1);
        @(posedge clk); #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("t5_b_dato_l_clr", b_dato_l, 0);
        chk("t5_a_dato_l_clr", a_dato_l, 0);
        repeat (4) @(negedge clk);
        chk("t5_no_valido", val_log.size(), v0);
        n1 = gnt_log.size();
        push_job(0, 1, 10, 32'h5A);
        push_job(1, 0, 9, 0);
        wait_idle("t5_done", 100);
        chk("t5_prio_a", g_port(n1), 0);
        chk("t5_reissue_data", v_dat(v0), 32'hCAFE0009);

        // Idle cycles do not move priority.
        push_job(0, 1, 11, 32'h77);
        wait_idle("t6_pre", 100);
        repeat (5) @(negedge clk);
        n0 = gnt_log.size();
        push_job(0, 1, 12, 32'h12);
        push_job(1, 1, 13, 32'h13);
        wait_idle("t6_done", 100);
        chk("t6_prio_b", g_port(n0), 1);

        // Randomized traffic with small address range and occasional abandons.
        for (int i = 0; i < 300; i++) begin
            int p;
            p = i % 2;
            push_job(p, 1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom,
                     $urandom_range(0, 3),
                     ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2) : 0);
        end
        wait_idle("rand_done", 5000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
